// File: rtl/command_credit_round_robin_arbiter_if.sv
// ---------------------------------------------------------------------------
// command_credit_round_robin_arbiter_if
//
// Purpose:
//   Defines the command struct-type tag and the bundle that connects the
//   command producers and the downstream struct-type demux to the arbiter.
//
// Contents:
//   command_credit_round_robin_arbiter_pkg - array_struct_type tag enum.
//   command_credit_round_robin_arbiter_if  - request/command/credit bundle.
//
// Interface signals (direction seen from the arbiter, modport slave):
//   enable_in            in   arbitration enable
//   req_data_in[i]       in   per-requester command payload
//   req_sel_in[i]        in   per-requester struct tag
//   req_valid_in[i]      in   per-requester valid
//   req_ready_out[i]     out  holding register i can accept
//   credit_return_in     in   downstream freed one slot (one-cycle pulse)
//   data_out             out  granted payload   (demux data_in)
//   sel_out              out  granted tag       (demux sel_in)
//   data_out_valid       out  granted valid     (demux data_in_valid)
//   credits_out          out  current credit count
//   credit_overflow_out  out  sticky credit-overflow error
//
// Modports: master = producers plus downstream stage, slave = arbiter.
// ---------------------------------------------------------------------------
package command_credit_round_robin_arbiter_pkg;

    typedef enum logic [2:0] {
        STRUCT_INVALID    = 3'd0,
        READ_GRAPH_DATA   = 3'd1,
        WRITE_GRAPH_DATA  = 3'd2,
        READ_VERTEX_DATA  = 3'd3,
        WRITE_VERTEX_DATA = 3'd4
    } array_struct_type;

endpackage : command_credit_round_robin_arbiter_pkg

interface command_credit_round_robin_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQUESTERS = 4,
    parameter int CREDITS        = 8
);
    import command_credit_round_robin_arbiter_pkg::*;

    localparam int CREDIT_WIDTH = $clog2(CREDITS + 1);

    logic                        enable_in;
    logic [0:DATA_WIDTH-1]       req_data_in [0:NUM_REQUESTERS-1];
    array_struct_type            req_sel_in  [0:NUM_REQUESTERS-1];
    logic [0:NUM_REQUESTERS-1]   req_valid_in;
    logic [0:NUM_REQUESTERS-1]   req_ready_out;
    logic                        credit_return_in;
    logic [0:DATA_WIDTH-1]       data_out;
    array_struct_type            sel_out;
    logic                        data_out_valid;
    logic [CREDIT_WIDTH-1:0]     credits_out;
    logic                        credit_overflow_out;

    modport master (
        output enable_in,
        output req_data_in,
        output req_sel_in,
        output req_valid_in,
        input  req_ready_out,
        output credit_return_in,
        input  data_out,
        input  sel_out,
        input  data_out_valid,
        input  credits_out,
        input  credit_overflow_out
    );

    modport slave (
        input  enable_in,
        input  req_data_in,
        input  req_sel_in,
        input  req_valid_in,
        output req_ready_out,
        input  credit_return_in,
        output data_out,
        output sel_out,
        output data_out_valid,
        output credits_out,
        output credit_overflow_out
    );

endinterface : command_credit_round_robin_arbiter_if

// File: rtl/command_credit_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// command_credit_round_robin_arbiter
//
// Purpose:
//   Shares one command path between NUM_REQUESTERS command producers. Each
//   producer owns a one-entry holding register; full entries are granted
//   round-robin while the credit counter (free slots in the downstream
//   struct-type demux) is non-zero. The granted command is registered and
//   drives the demux data_in / sel_in / data_in_valid directly.
//
// Ports:
//   clock  in  clock
//   rstn   in  asynchronous active-low reset
//   bus    command_credit_round_robin_arbiter_if.slave (see interface file)
//
// Parameters:
//   DATA_WIDTH      command payload width
//   NUM_REQUESTERS  number of producers (>= 2)
//   CREDITS         downstream slots; counter is $clog2(CREDITS+1) bits
//
// Build option:
//   ARB_GRAPH_PRIORITY_EN - when defined, held entries tagged READ_GRAPH_DATA
//   win over all others; the round-robin pointer is shared by both classes.
//   Undefined (default) gives pure round-robin regardless of tag.
// ---------------------------------------------------------------------------
module command_credit_round_robin_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQUESTERS = 4,
    parameter int CREDITS        = 8
) (
    input  logic clock,
    input  logic rstn,
    command_credit_round_robin_arbiter_if.slave bus
);
    import command_credit_round_robin_arbiter_pkg::*;

    localparam int CW    = $clog2(CREDITS + 1);
    localparam int PTR_W = $clog2(NUM_REQUESTERS);

    localparam logic [CW-1:0]    CREDITS_FULL = CW'(CREDITS);
    localparam logic [PTR_W:0]   N_EXT        = (PTR_W + 1)'(NUM_REQUESTERS);
    localparam logic [PTR_W-1:0] LAST_IDX     = PTR_W'(NUM_REQUESTERS - 1);

    typedef enum logic [1:0] {
        ARB_INIT = 2'd0,
        ARB_RUN  = 2'd1,
        ARB_HOLD = 2'd2
    } arb_state_t;

    // Registered state
    arb_state_t              state_q,     state_d;
    logic [0:NUM_REQUESTERS-1] held_q,    held_d;
    logic [0:DATA_WIDTH-1]   hold_data_q [0:NUM_REQUESTERS-1];
    logic [0:DATA_WIDTH-1]   hold_data_d [0:NUM_REQUESTERS-1];
    array_struct_type        hold_sel_q  [0:NUM_REQUESTERS-1];
    array_struct_type        hold_sel_d  [0:NUM_REQUESTERS-1];
    logic [PTR_W-1:0]        rr_q,        rr_d;
    logic [CW-1:0]           credits_q,   credits_d;
    logic                    overflow_q,  overflow_d;
    logic [0:DATA_WIDTH-1]   data_q,      data_d;
    array_struct_type        sel_q,       sel_d;
    logic                    valid_q,     valid_d;

    // Combinational grant / acceptance
    logic [0:NUM_REQUESTERS-1] eligible;
    logic [0:NUM_REQUESTERS-1] grant;
    logic [0:NUM_REQUESTERS-1] ready;
    logic                      grant_any;
    logic [PTR_W-1:0]          grant_idx;
    logic [PTR_W:0]            scan_sum;
    logic [PTR_W-1:0]          scan_idx;
`ifdef ARB_GRAPH_PRIORITY_EN
    logic [0:NUM_REQUESTERS-1] graph_held;
`endif

    // -----------------------------------------------------------------------
    // Grant selection: first eligible entry at or after rr_q, wrapping.
    // -----------------------------------------------------------------------
    always_comb begin : grant_select
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned (no inferred latch).
        eligible  = held_q;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
`ifdef ARB_GRAPH_PRIORITY_EN
        graph_held = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            graph_held[i] = held_q[i] && (hold_sel_q[i] == READ_GRAPH_DATA);
        end
        // Graph-data reads pre-empt everything else while any is waiting.
        if (|graph_held) begin
            eligible = graph_held;
        end
`endif
        if ((state_q == ARB_RUN) && (credits_q != '0)) begin
            for (int k = 0; k < NUM_REQUESTERS; k++) begin
                // rr_q + k is below 2*N, so one conditional subtract wraps it.
                scan_sum = {1'b0, rr_q} + (PTR_W + 1)'(k);
                if (scan_sum >= N_EXT) begin
                    scan_sum = scan_sum - N_EXT;
                end
                scan_idx = scan_sum[PTR_W-1:0];
                if (!grant_any && eligible[scan_idx]) begin
                    grant_any       = 1'b1;
                    grant_idx       = scan_idx;
                    grant[scan_idx] = 1'b1;
                end
            end
        end
    end

    // An entry can take a new command when empty or when it is leaving this
    // cycle; nothing is accepted until credits are loaded.
    always_comb begin : ready_logic
        ready = '0;
        if (state_q != ARB_INIT) begin
            ready = ~held_q | grant;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin : next_state
        state_d     = state_q;
        held_d      = held_q;
        hold_data_d = hold_data_q;
        hold_sel_d  = hold_sel_q;
        rr_d        = rr_q;
        credits_d   = credits_q;
        overflow_d  = overflow_q;
        data_d      = data_q;
        sel_d       = sel_q;
        valid_d     = 1'b0;

        // Control FSM
        unique case (state_q)
            ARB_INIT: begin
                credits_d = CREDITS_FULL;
                state_d   = bus.enable_in ? ARB_RUN : ARB_HOLD;
            end
            ARB_RUN: begin
                if (!bus.enable_in) begin
                    state_d = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (bus.enable_in) begin
                    state_d = ARB_RUN;
                end
            end
            default: begin
                state_d = ARB_INIT;
            end
        endcase

        // Holding registers: a granted entry empties unless reloaded on the
        // same edge. STRUCT_INVALID commands are taken but never stored.
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant[i]) begin
                held_d[i] = 1'b0;
            end
            if (bus.req_valid_in[i] && ready[i]) begin
                if (bus.req_sel_in[i] != STRUCT_INVALID) begin
                    held_d[i]      = 1'b1;
                    hold_data_d[i] = bus.req_data_in[i];
                    hold_sel_d[i]  = bus.req_sel_in[i];
                end else begin
                    held_d[i] = 1'b0;
                end
            end
        end

        // Output register and pointer advance
        if (grant_any) begin
            valid_d = 1'b1;
            data_d  = hold_data_q[grant_idx];
            sel_d   = hold_sel_q[grant_idx];
            rr_d    = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
        end

        // Credit accounting; a simultaneous grant and return cancel out.
        if (state_q != ARB_INIT) begin
            if (grant_any && !bus.credit_return_in) begin
                credits_d = credits_q - CW'(1);
            end else if (!grant_any && bus.credit_return_in) begin
                if (credits_q == CREDITS_FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    credits_d = credits_q + CW'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ARB_INIT;
            held_q     <= '0;
            rr_q       <= '0;
            credits_q  <= '0;
            overflow_q <= 1'b0;
            data_q     <= '0;
            sel_q      <= STRUCT_INVALID;
            valid_q    <= 1'b0;
            // NOTE: the payload registers are reset as well; they are only a
            // few words and a known value keeps data_out clean after reset.
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                hold_data_q[i] <= '0;
                hold_sel_q[i]  <= STRUCT_INVALID;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed from the previous cycle's state.
            state_q     <= state_d;
            held_q      <= held_d;
            hold_data_q <= hold_data_d;
            hold_sel_q  <= hold_sel_d;
            rr_q        <= rr_d;
            credits_q   <= credits_d;
            overflow_q  <= overflow_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            valid_q     <= valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.req_ready_out       = ready;
    assign bus.data_out            = data_q;
    assign bus.sel_out             = sel_q;
    assign bus.data_out_valid      = valid_q;
    assign bus.credits_out         = credits_q;
    assign bus.credit_overflow_out = overflow_q;

endmodule : command_credit_round_robin_arbiter

// File: tb/tb_command_credit_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// tb_command_credit_round_robin_arbiter
//
// Self-checking bench: a table of per-cycle vectors for the saturating
// stream, credit starvation/return and overflow, then short hand-written
// sequences for reset, single command latency, invalid tags, enable
// hold-off, mid-operation reset and (build dependent) graph priority.
// ---------------------------------------------------------------------------
module tb_command_credit_round_robin_arbiter;
    import command_credit_round_robin_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int CR = 8;
    localparam int CW = $clog2(CR + 1);

    logic clock = 1'b0;
    logic rstn  = 1'b0;

    always #5 clock = ~clock;

    command_credit_round_robin_arbiter_if #(
        .DATA_WIDTH(DW), .NUM_REQUESTERS(N), .CREDITS(CR)
    ) bus ();

    command_credit_round_robin_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQUESTERS(N), .CREDITS(CR)
    ) u_dut (
        .clock (clock),
        .rstn  (rstn),
        .bus   (bus)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    typedef struct {
        logic          en;
        logic [0:N-1]  valid;
        logic          ret;
        logic          exp_valid;
        int            exp_gnt;
        logic [CW-1:0] exp_credits;
        logic [0:N-1]  exp_ready;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [0:N-1] valid,
                                input logic ret, input logic exp_valid,
                                input int exp_gnt, input int exp_credits,
                                input logic [0:N-1] exp_ready,
                                input logic exp_ovf);
        vec_t v;
        v.en          = en;
        v.valid       = valid;
        v.ret         = ret;
        v.exp_valid   = exp_valid;
        v.exp_gnt     = exp_gnt;
        v.exp_credits = CW'(exp_credits);
        v.exp_ready   = exp_ready;
        v.exp_ovf     = exp_ovf;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        bus.req_valid_in     = '0;
        bus.credit_return_in = 1'b0;
    endtask

    task automatic load_stream_payloads();
        for (int i = 0; i < N; i++) begin
            bus.req_data_in[i] = 32'hC0DE_0000 + DW'(i);
            bus.req_sel_in[i]  = READ_VERTEX_DATA;
        end
    endtask

    task automatic reset_dut();
        set_idle();
        @(negedge clock);
        rstn = 1'b0;
        @(negedge clock);
        rstn = 1'b1;
    endtask

    // Watchdog: the run is a few hundred cycles; anything longer is a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.enable_in = 1'b1;
        set_idle();
        load_stream_payloads();

        // ----------------------------------------------------------------
        // Vector table (inputs applied before the edge, outputs checked
        // just after it). Masks list requester 0 first.
        //        en valid   ret v  gnt cred ready   ovf
        // ----------------------------------------------------------------
        // Saturating stream: 8 grants 0,1,2,3,0,1,2,3 then starvation.
        vecs.push_back(mk(1, 4'b1111, 0, 0, 0, 8, 4'b1111, 0)); // ARB_INIT -> RUN
        vecs.push_back(mk(1, 4'b1111, 0, 0, 0, 8, 4'b1000, 0)); // all accepted
        vecs.push_back(mk(1, 4'b1111, 0, 1, 0, 7, 4'b0100, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 1, 6, 4'b0010, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 2, 5, 4'b0001, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 3, 4, 4'b1000, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 0, 3, 4'b0100, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 1, 2, 4'b0010, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 2, 1, 4'b0001, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 1, 3, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 0)); // out of credits
        // One return at zero credits -> exactly one grant, back to zero.
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 1, 4'b1000, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 4'b1000, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'b1000, 0));
        // Returns while draining: grant + return in one cycle holds the count.
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 1, 4'b1100, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 1, 1, 1, 4'b1110, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 1, 2, 1, 4'b1111, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 1, 3, 1, 4'b1111, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 2, 4'b1111, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 3, 4'b1111, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 4, 4'b1111, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 5, 4'b1111, 0));
        // Credits = 5: grant and return on the same edge keep 5.
        vecs.push_back(mk(1, 4'b1000, 0, 0, 0, 5, 4'b1111, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 1, 0, 5, 4'b1111, 0));
        // Refill to 8, then one more return saturates and sets overflow.
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 6, 4'b1111, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 7, 4'b1111, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 8, 4'b1111, 0));
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 8, 4'b1111, 1));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 8, 4'b1111, 1)); // sticky

        // ---------------- reset state ----------------
        #12;
        check("reset.data_out", 64'(bus.data_out), 64'h0);
        check("reset.sel_out", 64'(bus.sel_out), 64'(STRUCT_INVALID));
        check("reset.valid", 64'(bus.data_out_valid), 64'h0);
        check("reset.credits", 64'(bus.credits_out), 64'h0);
        check("reset.overflow", 64'(bus.credit_overflow_out), 64'h0);
        check("reset.ready", 64'(bus.req_ready_out), 64'h0);
        @(negedge clock);
        rstn = 1'b1;

        // ---------------- table ----------------
        foreach (vecs[v]) begin
            bus.enable_in        = vecs[v].en;
            bus.req_valid_in     = vecs[v].valid;
            bus.credit_return_in = vecs[v].ret;
            tick();
            check($sformatf("vec%0d.valid", v), 64'(bus.data_out_valid),
                  64'(vecs[v].exp_valid));
            check($sformatf("vec%0d.credits", v), 64'(bus.credits_out),
                  64'(vecs[v].exp_credits));
            check($sformatf("vec%0d.ready", v), 64'(bus.req_ready_out),
                  64'(vecs[v].exp_ready));
            check($sformatf("vec%0d.overflow", v), 64'(bus.credit_overflow_out),
                  64'(vecs[v].exp_ovf));
            if (vecs[v].exp_valid) begin
                check($sformatf("vec%0d.data", v), 64'(bus.data_out),
                      64'(32'hC0DE_0000 + DW'(vecs[v].exp_gnt)));
                check($sformatf("vec%0d.sel", v), 64'(bus.sel_out),
                      64'(READ_VERTEX_DATA));
            end
        end
        set_idle();

        // ---------------- reset mid-operation ----------------
        bus.req_valid_in = 4'b1000;   // entry 0 filled, grant would follow
        tick();
        set_idle();
        rstn = 1'b0;
        #1;
        check("midrst.valid", 64'(bus.data_out_valid), 64'h0);
        check("midrst.data_out", 64'(bus.data_out), 64'h0);
        check("midrst.credits", 64'(bus.credits_out), 64'h0);
        check("midrst.overflow", 64'(bus.credit_overflow_out), 64'h0);
        @(negedge clock);
        rstn = 1'b1;
        tick();
        check("midrst.init_credits", 64'(bus.credits_out), 64'd8);
        tick();
        check("midrst.no_output1", 64'(bus.data_out_valid), 64'h0);
        tick();
        check("midrst.no_output2", 64'(bus.data_out_valid), 64'h0);
        check("midrst.credits_kept", 64'(bus.credits_out), 64'd8);

        // ---------------- single command, requester 2 ----------------
        bus.req_data_in[2] = 32'hDEAD_BEEF;
        bus.req_sel_in[2]  = READ_GRAPH_DATA;
        bus.req_valid_in   = 4'b0010;
        tick();
        set_idle();
        check("single.not_yet", 64'(bus.data_out_valid), 64'h0);
        tick();
        check("single.valid", 64'(bus.data_out_valid), 64'h1);
        check("single.data", 64'(bus.data_out), 64'hDEAD_BEEF);
        check("single.sel", 64'(bus.sel_out), 64'(READ_GRAPH_DATA));
        check("single.credits", 64'(bus.credits_out), 64'd7);
        tick();
        check("single.one_cycle", 64'(bus.data_out_valid), 64'h0);
        check("single.data_kept", 64'(bus.data_out), 64'hDEAD_BEEF);

        // ---------------- STRUCT_INVALID is dropped ----------------
        bus.req_sel_in[1]  = STRUCT_INVALID;
        bus.req_data_in[1] = 32'h1111_1111;
        bus.req_valid_in   = 4'b0100;
        #1;
        check("invalid.ready", 64'(bus.req_ready_out), 64'(4'b1111));
        tick();
        set_idle();
        check("invalid.no_out1", 64'(bus.data_out_valid), 64'h0);
        check("invalid.not_held", 64'(bus.req_ready_out), 64'(4'b1111));
        tick();
        check("invalid.no_out2", 64'(bus.data_out_valid), 64'h0);
        check("invalid.credits", 64'(bus.credits_out), 64'd7);

        // ---------------- enable low holds, entries still accept ----------
        bus.enable_in = 1'b0;
        tick();                                  // RUN -> HOLD
        bus.req_data_in[3] = 32'h3333_0003;
        bus.req_sel_in[3]  = WRITE_GRAPH_DATA;
        bus.req_valid_in   = 4'b0001;
        tick();
        set_idle();
        check("hold.accepted", 64'(bus.req_ready_out), 64'(4'b1110));
        tick();
        check("hold.no_grant", 64'(bus.data_out_valid), 64'h0);
        check("hold.credits", 64'(bus.credits_out), 64'd7);
        bus.enable_in = 1'b1;
        tick();                                  // HOLD -> RUN, no grant yet
        check("hold.resume_edge", 64'(bus.data_out_valid), 64'h0);
        tick();
        check("hold.valid", 64'(bus.data_out_valid), 64'h1);
        check("hold.data_preserved", 64'(bus.data_out), 64'h3333_0003);
        check("hold.sel", 64'(bus.sel_out), 64'(WRITE_GRAPH_DATA));
        check("hold.credits_after", 64'(bus.credits_out), 64'd6);

        // ---------------- tag priority (build dependent) ----------------
        bus.enable_in = 1'b0;
        reset_dut();
        tick();                                  // ARB_INIT -> ARB_HOLD, rr = 0
        bus.req_data_in[0] = 32'hAAAA_0000;
        bus.req_sel_in[0]  = READ_VERTEX_DATA;
        bus.req_data_in[3] = 32'hBBBB_0003;
        bus.req_sel_in[3]  = READ_GRAPH_DATA;
        bus.req_valid_in   = 4'b1001;
        tick();
        set_idle();
        bus.enable_in = 1'b1;
        tick();                                  // HOLD -> RUN
        check("prio.no_grant_in_hold", 64'(bus.data_out_valid), 64'h0);
        tick();
        check("prio.first_valid", 64'(bus.data_out_valid), 64'h1);
`ifdef ARB_GRAPH_PRIORITY_EN
        check("prio.first_data", 64'(bus.data_out), 64'hBBBB_0003);
`else
        check("prio.first_data", 64'(bus.data_out), 64'hAAAA_0000);
`endif
        tick();
        check("prio.second_valid", 64'(bus.data_out_valid), 64'h1);
`ifdef ARB_GRAPH_PRIORITY_EN
        check("prio.second_data", 64'(bus.data_out), 64'hAAAA_0000);
`else
        check("prio.second_data", 64'(bus.data_out), 64'hBBBB_0003);
`endif
        check("prio.credits", 64'(bus.credits_out), 64'd6);
        tick();
        check("prio.idle", 64'(bus.data_out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_command_credit_round_robin_arbiter

// File: doc/command_credit_round_robin_arbiter.md
Name: command_credit_round_robin_arbiter

Overview:
Shares one command path between NUM_REQUESTERS command producers, such as the per-engine read/write command generators in the PageRank PULL global CU. Each producer's command (data plus array_struct_type tag) is held in a one-entry register. Holding registers are granted round-robin, gated by a credit counter that tracks free slots in the downstream struct-type filter/demux stage. Output is registered and drives that demux's data_in/sel_in/data_in_valid directly.

Parameters:
DATA_WIDTH, 32, width of command payload
NUM_REQUESTERS, 4, number of requesters (>=2)
CREDITS, 8, downstream slots; credit counter width is $clog2(CREDITS+1)

Ports:
clock  input  1  clock
rstn  input  1  reset, asynchronous, active-low
enable_in  input  1  arbitration enable
req_data_in  input  [0:DATA_WIDTH-1] x [0:NUM_REQUESTERS-1]  request payloads
req_sel_in  input  array_struct_type x [0:NUM_REQUESTERS-1]  request struct tags
req_valid_in  input  1 x [0:NUM_REQUESTERS-1]  request valid
req_ready_out  output  1 x [0:NUM_REQUESTERS-1]  holding register can accept
credit_return_in  input  1  one-cycle pulse; downstream freed one slot
data_out  output  [0:DATA_WIDTH-1]  granted payload
sel_out  output  array_struct_type  granted struct tag
data_out_valid  output  1  granted command valid
credits_out  output  $clog2(CREDITS+1)  current credit count
credit_overflow_out  output  1  sticky error flag

Behaviour:
- Reset, asynchronous, active-low:
  - data_out=0, sel_out=STRUCT_INVALID, data_out_valid=0, credits_out=0, credit_overflow_out=0.
  - All holding registers empty; rr pointer=0; FSM=ARB_INIT.
- FSM:
  - ARB_INIT: one cycle; loads credits=CREDITS; always goes to ARB_RUN if enable_in=1, else ARB_HOLD.
  - ARB_RUN: grants allowed. Goes to ARB_HOLD when enable_in=0.
  - ARB_HOLD: no grants; holding registers still accept. Goes to ARB_RUN when enable_in=1.
- Acceptance:
  - req_ready_out[i] = ~held[i] | grant[i], combinational; req_ready_out=0 in ARB_INIT.
  - On valid&ready, payload and tag load into holding register i at the clock edge.
  - A request tagged STRUCT_INVALID is accepted and dropped: held[i] stays 0 and no credit is consumed.
- Grant (combinational, from registered state):
  - Grant only in ARB_RUN with credits>0.
  - Grant the first held[i] scanning from rr pointer upward, wrapping modulo NUM_REQUESTERS.
  - At most one grant per cycle.
- On grant of i at an edge:
  - data_out/sel_out load from holding register i; data_out_valid=1.
  - held[i] clears, unless reloaded the same edge.
  - rr pointer = (i+1) mod NUM_REQUESTERS.
- With no grant, data_out_valid=0 next cycle; data_out/sel_out keep their last values.
- Latency: acceptance at edge E0 gives data_out_valid at E1 at the earliest. Sustained throughput is 1 command/cycle when credits>0.
- Credits:
  - Grant alone: -1. credit_return_in alone: +1. Both in the same cycle: unchanged.
  - Return while credits==CREDITS and no grant: count saturates and credit_overflow_out sets (sticky until reset).
  - credits==0: no grants, holding registers stay full, req_ready_out=0 for full entries.
- enable_in falling mid-stream: an output already registered stays valid for its cycle; no new grant in ARB_HOLD. Held data is preserved.
- Reset mid-operation: all held commands are discarded; no partial output.

Optional Feature:
ARB_GRAPH_PRIORITY_EN:
- Defined: if any held entry has sel==READ_GRAPH_DATA, round-robin runs only among those entries (same rr pointer); otherwise normal round-robin.
- Undefined: pure round-robin regardless of tag.

Test Plan:
- Reset, then all 4 requesters valid each cycle with CREDITS=8 and no returns -> grants in order 0,1,2,3,0,1,2,3. Exactly 8 outputs, then credits_out=0 and data_out_valid=0.
- Requester 2 sends 0xDEADBEEF tagged READ_GRAPH_DATA while idle -> data_out=0xDEADBEEF, sel_out=READ_GRAPH_DATA, valid one cycle after acceptance; credits_out 8->7.
- credits_out=0, credit_return_in pulse while 3 entries held -> exactly one grant next cycle; credits_out returns to 0.
- Grant and credit_return_in in the same cycle at credits=5 -> credits_out stays 5. Return pulse at credits=8 with no grant -> credits_out stays 8, credit_overflow_out=1.
- Requester 1 sends a STRUCT_INVALID-tagged request -> accepted (ready=1), no output, credits unchanged.
- With ARB_GRAPH_PRIORITY_EN: entries 0 and 3 held, 3 tagged READ_GRAPH_DATA, rr=0 -> grant 3 first, then 0.
